// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, entry type and select helper for the hazard scoreboard unit
package hazard_pkg;

  // Default register index width for the packed entry type below.
  localparam int PKG_REG_AW = 5;

  // Operand select value meaning "take the register file".
  localparam int SEL_NONE = 0;

  typedef struct packed {
    logic                  valid;
    logic [PKG_REG_AW-1:0] rd;
  } sb_entry_t;

  // Operand select value that picks forwarding stage k.
  function automatic int sel_of_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// rtl/hazard_scoreboard_unit_if.sv - EX-side bus of the hazard scoreboard unit (perf outputs under HAZARD_PERF_CNT_EN)
interface hazard_scoreboard_unit_if #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int SB_DEPTH = 4,
  parameter int REG_AW   = 5
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int TAG_W = $clog2(SB_DEPTH);

  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]        ex_rs_used;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic                      issue_ready;
  logic [TAG_W-1:0]          issue_tag;
  logic                      cpl_valid;
  logic [TAG_W-1:0]          cpl_tag;
  logic                      flush;
  logic                      stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]               perf_stall_cnt;
  logic [31:0]               perf_fwd_cnt;
`endif

  // Pipeline side: drives operands, forwarding stages, issue/completion and flush.
  modport master (
    output ex_rs, ex_rs_used, fwd_rd, fwd_we, issue_valid, issue_rd,
           cpl_valid, cpl_tag, flush,
    input  fwd_sel, issue_ready, issue_tag, stall
`ifdef HAZARD_PERF_CNT_EN
    , input perf_stall_cnt, perf_fwd_cnt
`endif
  );

  // Hazard unit side.
  modport slave (
    input  ex_rs, ex_rs_used, fwd_rd, fwd_we, issue_valid, issue_rd,
           cpl_valid, cpl_tag, flush,
    output fwd_sel, issue_ready, issue_tag, stall
`ifdef HAZARD_PERF_CNT_EN
    , output perf_stall_cnt, perf_fwd_cnt
`endif
  );

endinterface

// File: rtl/sb_free_finder.sv
// rtl/sb_free_finder.sv - lowest-index free entry priority encoder for the scoreboard
module sb_free_finder
  import hazard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  output logic             any_free,
  output logic [IDX_W-1:0] free_idx
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - EX forwarding select plus long-latency write scoreboard (optional HAZARD_PERF_CNT_EN)
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int SB_DEPTH = 4,
  parameter int REG_AW   = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int TAG_W = $clog2(SB_DEPTH);

  logic [SB_DEPTH-1:0]      sb_valid;
  logic [REG_AW-1:0]        sb_rd [SB_DEPTH];
  logic                     any_free;
  logic [TAG_W-1:0]         free_idx;
  logic [NUM_SRC*SEL_W-1:0] sel;
  logic                     stall_c;
  logic                     waw;
  logic                     issue_ready_c;
  logic                     alloc;

  sb_free_finder #(
    .DEPTH (SB_DEPTH),
    .IDX_W (TAG_W)
  ) u_free_finder (
    .valid    (sb_valid),
    .any_free (any_free),
    .free_idx (free_idx)
  );

  // Operand selects: walk oldest to youngest so the youngest matching stage wins; x0 never forwards.
  always_comb begin
    sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sel[s*SEL_W +: SEL_W] = SEL_W'(SEL_NONE);
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (bus.ex_rs[s*REG_AW +: REG_AW] != '0 && bus.fwd_we[k] &&
            bus.fwd_rd[k*REG_AW +: REG_AW] == bus.ex_rs[s*REG_AW +: REG_AW]) begin
          sel[s*SEL_W +: SEL_W] = SEL_W'(sel_of_stage(k));
        end
      end
    end
  end

  // Stall when a used, non-x0 source is the destination of any pending long-latency write.
  always_comb begin
    stall_c = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int j = 0; j < SB_DEPTH; j++) begin
        if (bus.ex_rs_used[s] && bus.ex_rs[s*REG_AW +: REG_AW] != '0 &&
            sb_valid[j] && sb_rd[j] == bus.ex_rs[s*REG_AW +: REG_AW]) begin
          stall_c = 1'b1;
        end
      end
    end
  end

  // WAW check against pending destinations; uses pre-completion state so a freed slot waits a cycle.
  always_comb begin
    waw = 1'b0;
    for (int j = 0; j < SB_DEPTH; j++) begin
      if (sb_valid[j] && sb_rd[j] == bus.issue_rd) begin
        waw = 1'b1;
      end
    end
  end

  assign issue_ready_c   = any_free && !waw && !bus.flush;
  assign alloc           = bus.issue_valid && issue_ready_c && (bus.issue_rd != '0);

  assign bus.fwd_sel     = sel;
  assign bus.stall       = stall_c;
  assign bus.issue_ready = issue_ready_c;
  assign bus.issue_tag   = alloc ? free_idx : '0;

  // Entry state: flush wins over everything; an allocation overrides a stray completion of a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      for (int j = 0; j < SB_DEPTH; j++) begin
        sb_rd[j] <= '0;
      end
    end else if (bus.flush) begin
      sb_valid <= '0;
    end else begin
      if (bus.cpl_valid) begin
        sb_valid[bus.cpl_tag] <= 1'b0;
      end
      if (alloc) begin
        sb_valid[free_idx] <= 1'b1;
        sb_rd[free_idx]    <= bus.issue_rd;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic        fwd_hit;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_fwd_q;

  // A cycle counts as forwarding when any used operand takes a stage instead of the register file.
  always_comb begin
    fwd_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.ex_rs_used[s] && sel[s*SEL_W +: SEL_W] != SEL_W'(SEL_NONE)) begin
        fwd_hit = 1'b1;
      end
    end
  end

  // Free-running event counters; wrap naturally and survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(stall_c);
      perf_fwd_q   <= perf_fwd_q + 32'(fwd_hit);
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  localparam int NS = 2;
  localparam int NF = 2;
  localparam int SD = 4;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if bus_i ();

  hazard_scoreboard_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: destination register of each pending write, -1 when the slot is free.
  int pend [SD] = '{-1, -1, -1, -1};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int rs_of(input int s);
    return int'(bus_i.ex_rs[s*AW +: AW]);
  endfunction

  // Expected selects packed 2 bits per operand: first (youngest) writing stage whose rd matches.
  function automatic int m_sel();
    int r = 0;
    for (int s = 0; s < NS; s++) begin
      int pick = 0;
      if (rs_of(s) != 0) begin
        for (int k = 0; k < NF; k++) begin
          if (pick == 0 && bus_i.fwd_we[k] && int'(bus_i.fwd_rd[k*AW +: AW]) == rs_of(s)) pick = k + 1;
        end
      end
      r = r | (pick << (2 * s));
    end
    return r;
  endfunction

  function automatic int m_stall();
    for (int s = 0; s < NS; s++) begin
      if (bus_i.ex_rs_used[s] && rs_of(s) != 0) begin
        for (int j = 0; j < SD; j++) if (pend[j] == rs_of(s)) return 1;
      end
    end
    return 0;
  endfunction

  function automatic int m_ready();
    int nfree = 0;
    for (int j = 0; j < SD; j++) begin
      if (pend[j] < 0) nfree++;
      if (pend[j] == int'(bus_i.issue_rd)) return 0;
    end
    return (nfree > 0 && !bus_i.flush) ? 1 : 0;
  endfunction

  function automatic int m_tag();
    if (!(bus_i.issue_valid && m_ready() == 1 && bus_i.issue_rd != 0)) return 0;
    for (int j = 0; j < SD; j++) if (pend[j] < 0) return j;
    return 0;
  endfunction

  // Model update at each clock edge, from pre-edge state and the inputs held across the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SD; j++) pend[j] = -1;
    end else if (bus_i.flush) begin
      for (int j = 0; j < SD; j++) pend[j] = -1;
    end else begin
      int  t;
      bit  a;
      a = bus_i.issue_valid && m_ready() == 1 && bus_i.issue_rd != 0;
      t = m_tag();
      if (bus_i.cpl_valid) pend[bus_i.cpl_tag] = -1;
      if (a) pend[t] = int'(bus_i.issue_rd);
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_fwd_sel", int'(bus_i.fwd_sel), m_sel());
      chk("model_stall", int'(bus_i.stall), m_stall());
      chk("model_issue_ready", int'(bus_i.issue_ready), m_ready());
      if (bus_i.issue_valid && m_ready() == 1) chk("model_issue_tag", int'(bus_i.issue_tag), m_tag());
    end
  end

  task automatic idle();
    bus_i.ex_rs       = '0;
    bus_i.ex_rs_used  = '0;
    bus_i.fwd_rd      = '0;
    bus_i.fwd_we      = '0;
    bus_i.issue_valid = 1'b0;
    bus_i.issue_rd    = '0;
    bus_i.cpl_valid   = 1'b0;
    bus_i.cpl_tag     = '0;
    bus_i.flush       = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    idle();
    #2;
    chk("reset_stall", int'(bus_i.stall), 0);
    chk("reset_issue_ready", int'(bus_i.issue_ready), 1);
    chk("reset_issue_tag", int'(bus_i.issue_tag), 0);
    chk("reset_fwd_sel", int'(bus_i.fwd_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Forward priority: youngest stage wins, then the older one once the youngest stops writing.
    nxt(); idle();
    bus_i.ex_rs = 10'd165; bus_i.fwd_rd = 10'd165; bus_i.fwd_we = 2'b11;
    mid(); chk("fwd_both_stage0", int'(bus_i.fwd_sel), 5);
    nxt(); bus_i.fwd_we = 2'b10;
    mid(); chk("fwd_both_stage1", int'(bus_i.fwd_sel), 10);

    // x0 never forwards; a non-writing stage never forwards.
    nxt(); idle(); bus_i.fwd_we = 2'b01;
    mid(); chk("fwd_x0", int'(bus_i.fwd_sel), 0);
    nxt(); idle(); bus_i.ex_rs = 10'd7; bus_i.fwd_rd = 10'd7;
    mid(); chk("fwd_no_we", int'(bus_i.fwd_sel), 0);

    // Long-latency dependency, used operand.
    nxt(); idle(); bus_i.issue_valid = 1'b1; bus_i.issue_rd = 5'd9;
    mid(); chk("dep_issue_ready", int'(bus_i.issue_ready), 1); chk("dep_issue_tag", int'(bus_i.issue_tag), 0);
    nxt(); idle(); bus_i.ex_rs = 10'd9; bus_i.ex_rs_used = 2'b01;
    mid(); chk("dep_stall", int'(bus_i.stall), 1);
    nxt(); bus_i.cpl_valid = 1'b1; bus_i.cpl_tag = 2'd0;
    mid(); chk("dep_stall_cpl_cycle", int'(bus_i.stall), 1);
    nxt(); bus_i.cpl_valid = 1'b0;
    mid(); chk("dep_stall_after_cpl", int'(bus_i.stall), 0);

    // Same dependency with the operand unused.
    nxt(); idle(); bus_i.issue_valid = 1'b1; bus_i.issue_rd = 5'd9;
    mid(); chk("unused_issue_tag", int'(bus_i.issue_tag), 0);
    nxt(); idle(); bus_i.ex_rs = 10'd9;
    mid(); chk("unused_stall", int'(bus_i.stall), 0);
    nxt(); bus_i.cpl_valid = 1'b1; bus_i.cpl_tag = 2'd0;
    mid(); chk("unused_stall_cpl", int'(bus_i.stall), 0);
    nxt(); bus_i.cpl_valid = 1'b0;
    mid(); chk("unused_stall_after", int'(bus_i.stall), 0);

    // Fill the scoreboard.
    for (int i = 0; i < SD; i++) begin
      nxt(); idle(); bus_i.issue_valid = 1'b1; bus_i.issue_rd = 5'(i + 1);
      mid(); chk("fill_ready", int'(bus_i.issue_ready), 1); chk("fill_tag", int'(bus_i.issue_tag), i);
    end
    nxt(); bus_i.issue_rd = 5'd5;
    mid(); chk("full_ready", int'(bus_i.issue_ready), 0);
    nxt(); bus_i.issue_rd = 5'd6; bus_i.cpl_valid = 1'b1; bus_i.cpl_tag = 2'd2;
    mid(); chk("cpl_issue_same_cycle", int'(bus_i.issue_ready), 0);
    nxt(); bus_i.cpl_valid = 1'b0;
    mid(); chk("reuse_ready", int'(bus_i.issue_ready), 1); chk("reuse_tag", int'(bus_i.issue_tag), 2);
    nxt(); idle(); bus_i.cpl_valid = 1'b1; bus_i.cpl_tag = 2'd3;
    nxt(); idle(); bus_i.issue_valid = 1'b1; bus_i.issue_rd = 5'd1;
    mid(); chk("waw_ready", int'(bus_i.issue_ready), 0);
    nxt(); bus_i.issue_rd = 5'd4;
    mid(); chk("after_waw_tag", int'(bus_i.issue_tag), 3);

    // Flush with three pending entries.
    nxt(); idle(); bus_i.cpl_valid = 1'b1; bus_i.cpl_tag = 2'd0;
    nxt(); idle(); bus_i.flush = 1'b1; bus_i.issue_valid = 1'b1; bus_i.issue_rd = 5'd8;
    bus_i.ex_rs = 10'd2; bus_i.ex_rs_used = 2'b01;
    mid(); chk("flush_stall_preflush", int'(bus_i.stall), 1); chk("flush_ready", int'(bus_i.issue_ready), 0);
    nxt(); bus_i.flush = 1'b0; bus_i.issue_valid = 1'b0;
    mid(); chk("post_flush_stall", int'(bus_i.stall), 0); chk("post_flush_ready", int'(bus_i.issue_ready), 1);

    // Stray completion on an empty scoreboard, then rd=0 issue allocates nothing.
    nxt(); idle(); bus_i.cpl_valid = 1'b1; bus_i.cpl_tag = 2'd3;
    nxt(); idle(); bus_i.issue_valid = 1'b1; bus_i.issue_rd = 5'd8;
    mid(); chk("stray_cpl_tag", int'(bus_i.issue_tag), 0);
    nxt(); bus_i.issue_rd = 5'd0;
    mid(); chk("rd0_ready", int'(bus_i.issue_ready), 1); chk("rd0_tag", int'(bus_i.issue_tag), 0);
    nxt(); bus_i.issue_rd = 5'd9;
    mid(); chk("after_rd0_tag", int'(bus_i.issue_tag), 1);

    // Asynchronous reset between edges with two pending entries.
    nxt(); idle(); bus_i.ex_rs = 10'd8; bus_i.ex_rs_used = 2'b01;
    mid(); chk("pre_reset_stall", int'(bus_i.stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_stall", int'(bus_i.stall), 0);
    chk("async_reset_ready", int'(bus_i.issue_ready), 1);
    chk("async_reset_tag", int'(bus_i.issue_tag), 0);
    #1 rst_n = 1'b1;
    mid(); chk("post_reset_stall", int'(bus_i.stall), 0);

    nxt(); idle();
    mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the EX-stage forwarding logic. For NUM_SRC EX source operands it selects among NUM_FWD forwarding stages, with the youngest stage taking priority. It adds a sequential scoreboard of up to SB_DEPTH in-flight variable-latency writes (MUL/DIV, cache-miss loads) and stalls EX while any used source depends on a pending write. It sits beside the EX stage and drives the operand muxes and the pipeline stall/hold logic.

Parameters:
NUM_SRC, 2, number of EX source operands (rs1, rs2, ...)
NUM_FWD, 2, number of forwarding stages; index 0 is the youngest (EX/MEM), index 1 is MEM/WB
SB_DEPTH, 4, scoreboard entries (max in-flight long-latency ops); must be ≥ 2
REG_AW, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_rs  in  NUM_SRC*REG_AW  EX source register indices; operand s occupies bits [s*REG_AW +: REG_AW]
ex_rs_used  in  NUM_SRC  operand s is actually read by the EX instruction
fwd_rd  in  NUM_FWD*REG_AW  destination register of each forwarding stage
fwd_we  in  NUM_FWD  stage k writes fwd_rd[k]
fwd_sel  out  NUM_SRC*SEL_W  per-operand select, SEL_W = $clog2(NUM_FWD+1); 0 = register file, k+1 = stage k
issue_valid  in  1  a long-latency op dispatches this cycle
issue_rd  in  REG_AW  destination of the dispatched op
issue_ready  out  1  scoreboard can accept the issue this cycle
issue_tag  out  $clog2(SB_DEPTH)  entry allocated; valid while issue_valid && issue_ready
cpl_valid  in  1  a long-latency op completes; its result is written back this cycle
cpl_tag  in  $clog2(SB_DEPTH)  tag of the completing op
flush  in  1  pipeline flush; discards all pending entries
stall  out  1  hold IF/ID/EX; EX operand is not yet available

Behaviour:
- State per entry: valid (1 bit) and rd (REG_AW bits). Reset clears every valid bit asynchronously. Nothing else is sequential unless the optional feature is compiled in.
- Reset output values: stall=0, issue_ready=1, issue_tag=0, fwd_sel=0 (combinational outputs driven from the cleared state).
- fwd_sel[s]:
  - If ex_rs[s]==0, or no stage matches, the select is 0.
  - Otherwise the select is k+1 for the lowest k with fwd_we[k] && fwd_rd[k]==ex_rs[s] && fwd_rd[k]!=0.
  - This is purely combinational with zero latency.
  - The select is computed regardless of ex_rs_used.
- stall: asserted iff some s has ex_rs_used[s] && ex_rs[s]!=0 and some valid entry has rd==ex_rs[s]. It is computed from registered state only.
  - A completion in cycle N clears its entry at the end of N, so stall drops in N+1.
  - The write-back in cycle N is covered by the normal forwarding path in N+1, or by the register file.
- issue_ready: 1 iff at least one entry is free AND no valid entry has rd==issue_rd AND flush==0. A WAW hazard refuses the issue.
- Issue with issue_rd==0: accepted whenever issue_ready=1; nothing is allocated; issue_tag=0.
- Allocation: on issue_valid && issue_ready && issue_rd!=0, the lowest-index free entry is set valid with rd=issue_rd, and issue_tag reports that index.
- Completion: cpl_valid clears entry cpl_tag. A cpl_tag that names an invalid entry is ignored, with no error.
- Simultaneous completion and issue in the same cycle:
  - issue_ready is evaluated on pre-completion state, so a slot freed in cycle N is allocatable in N+1 only.
  - A completion and an issue of the same rd in cycle N therefore refuse the issue.
- Full: all SB_DEPTH entries valid gives issue_ready=0; the issuer must hold the op.
- flush: clears all entries at the next edge and overrides any issue or completion in that cycle. stall is still evaluated on the pre-flush state in that cycle.
- Reset asserted mid-operation: all entries are dropped immediately, and outputs go to their reset values asynchronously.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds two outputs:
  - perf_stall_cnt[31:0]: counts cycles with stall=1.
  - perf_fwd_cnt[31:0]: counts cycles in which any fwd_sel is nonzero for a used operand.
- Both counters reset to 0, wrap modulo 2^32, and are not cleared by flush.
- When undefined, the ports and counters do not exist.

Decomposition:
- hazard_pkg holds:
  - SEL_NONE=0 constant.
  - The function sel_of_stage(k)=k+1.
  - A typedef sb_entry_t struct {logic valid; logic [REG_AW-1:0] rd;}, with REG_AW as the package default of 5.
- One sub-module, sb_free_finder: a parametrised lowest-free-index priority encoder producing an any_free flag and free_idx.

Test Plan:
- Forward priority: ex_rs={rs2=5,rs1=5}, fwd_rd={stage1=5, stage0=5}, fwd_we=2'b11 → both selects=1 (stage 0). Then clear fwd_we[0] → both selects=2.
- x0 and no-write: ex_rs1=0 with fwd_rd[0]=0 and fwd_we[0]=1 → select 0. ex_rs1=7 with fwd_rd[0]=7 and fwd_we=0 → select 0.
- Long-latency dependency:
  - Issue rd=9 → tag 0.
  - Next cycle ex_rs1=9 with used=1 → stall=1.
  - Completion of tag 0 in cycle N → stall=1 in N, stall=0 in N+1.
  - The same case with used=0 → stall=0 throughout.
- Full and WAW:
  - Issue rd=1,2,3,4 → tags 0,1,2,3; issue_ready=0.
  - Complete tag 2 and issue rd=6 in the same cycle → refused; the next cycle rd=6 gets tag 2.
  - Issue rd=1 while it is pending → issue_ready=0.
- Flush and stray completion:
  - With 3 entries pending, flush together with issue rd=8 → no allocation, issue_ready=0 that cycle; the next cycle all entries are free and stall=0.
  - cpl_valid with tag 3 on an empty scoreboard → no state change.
- Async reset: with 2 entries pending and stall=1, pulse rst_n low between edges → stall=0 and issue_ready=1 immediately, with no dependence on a clock edge.
